sseg_mux_ctrl: RTL and testbench
================================

Name: sseg_mux_ctrl

Overview:
- Four-digit, seven-segment display controller on the peripheral bus.
- Sits downstream of the peripheral address decoder and consumes its en7seg, en7segMSB and en7segLSB enables.
- Holds two 8-bit display registers (MSB byte, LSB byte) that the CPU writes and reads back.
- Time-multiplexes the four hex digits onto the board's shared common-anode display.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range 2..65535.
- CNT_W, 16: prescaler counter width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  bus write strobe.
- data_in  in  8  bus write data.
- en7seg  in  1  decoder: 7-seg block selected.
- en7segMSB  in  1  decoder: MSB register selected.
- en7segLSB  in  1  decoder: LSB register selected.
- data_out  out  8  read-back data (combinational).
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (asynchronous, active-high): msb_reg=0, lsb_reg=0, prescaler=0, digit index=0, an=4'b1111, seg=7'b1111111, dp=1.
  - Reset asserted mid-scan forces these values immediately.
  - The first digit shown after reset release is digit 0.
- Write: on a rising clk edge with we & en7seg:
  - msb_reg<=data_in if en7segMSB; lsb_reg<=data_in if en7segLSB.
  - If both selects are high, both registers load.
  - en7seg=0 or we=0 leaves both registers unchanged.
- Read (combinational): data_out = msb_reg when en7segMSB & en7seg; lsb_reg when en7segLSB & en7seg; else 8'h00.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 in the cycle where the count equals SCAN_DIV-1.
  - On tick, the digit index increments mod 4 (3 wraps to 0).
- Digit map:
  - idx0 = lsb_reg[3:0], idx1 = lsb_reg[7:4], idx2 = msb_reg[3:0], idx3 = msb_reg[7:4].
  - an is the one-hot-low pattern of idx (idx0 -> 4'b1110).
- Anti-ghosting: in the clock edge that consumes tick, an<=4'b1111 and seg<=7'b1111111 (one blank cycle). Normal drive resumes on the following edge with the new index.
- Outputs an/seg are registered:
  - 1-cycle latency from a register write or index change to the pins.
  - A write becomes visible on the very next non-blank cycle, with no need to wait for a scan wrap.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- A write on the same edge as tick: the register updates, the blank cycle proceeds, and the next digit shows the new value.

Optional Feature:
- SSEG_LZB_EN (leading-zero blanking).
- Defined: digit k (k=3..1) is blanked (an bit held 1, seg=1111111 in its slot) when that nibble and every higher nibble are 0. Digit 0 is never blanked, so value 0x0000 shows a single "0".
  - Scan timing is unchanged; blanked slots still last SCAN_DIV cycles.
- Undefined: all four digits are always driven, including leading zeros.

Test Plan:
- Reset: assert reset async mid-cycle -> an=1111, seg=1111111, dp=1 immediately. data_out=00 with en7seg=1, en7segMSB=1.
- Write/readback: SCAN_DIV=4. Write en7seg+en7segMSB with data_in=0x12, then en7seg+en7segLSB with data_in=0x34. Reads return 0x12 and 0x34.
- Scan order: after the writes above, observe the repeating sequence an=1110/seg=0011001 (4), blank, 1101/0110000 (3), blank, 1011/0100100 (2), blank, 0111/1111001 (1). Each digit is held 3 cycles plus 1 blank cycle; index wraps 3->0.
- Ignored write: we=1 with en7seg=0, data_in=0xFF -> both registers unchanged. Also we=0 with en7seg=1 -> no change.
- LZB (SSEG_LZB_EN defined): MSB=0x00, LSB=0x05 -> digits 3..1 an stay 1111 in their slots; digit 0 shows 0010010. Without the macro, digits 3..1 show 1000000.
- Reset mid-scan: reset asserted while idx=2 -> after release, the first driven digit is an=1110 and the registers read 0x00.

Source files
------------

// File: rtl/sseg_mux_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_mux_ctrl
// Four-digit common-anode seven-segment controller on the peripheral bus.
// Holds an MSB and an LSB display byte. Both bytes are writable and can be
// read back. The four hex nibbles are time-multiplexed onto the shared
// segment lines. Each digit slot lasts SCAN_DIV clocks. The last clock of
// every slot is blanked so that the previous digit does not ghost into the
// next one.
//
// Optional build macro:
//   SSEG_LZB_EN - leading-zero blanking. Digits 3..1 stay dark while their
//                 nibble and every higher nibble are zero. Digit 0 is
//                 always driven.
// ---------------------------------------------------------------------------
module sseg_mux_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] data_in,
    input  logic       en7seg,
    input  logic       en7segMSB,
    input  logic       en7segLSB,
    output logic [7:0] data_out,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [3:0]       AN_OFF    = 4'b1111;
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // One-hot-low anode pattern for a digit index (0 = rightmost).
    function automatic logic [3:0] idx_to_an(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = AN_OFF;
        endcase
        return pat;
    endfunction

    // Nibble shown in a given digit slot.
    function automatic logic [3:0] idx_to_nib(input logic [1:0] idx,
                                              input logic [7:0] msb,
                                              input logic [7:0] lsb);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = lsb[3:0];
            2'd1:    nib = lsb[7:4];
            2'd2:    nib = msb[3:0];
            2'd3:    nib = msb[7:4];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

`ifdef SSEG_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    function automatic logic is_leading_zero(input logic [1:0] idx,
                                             input logic [7:0] msb,
                                             input logic [7:0] lsb);
        logic lz;
        case (idx)
            2'd3:    lz = (msb[7:4] == 4'h0);
            2'd2:    lz = (msb == 8'h00);
            2'd1:    lz = (msb == 8'h00) && (lsb[7:4] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction
`endif

    logic [7:0]       msb_reg_r;
    logic [7:0]       lsb_reg_r;
    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] presc_nxt_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_nxt_s;
    logic             tick_s;
    logic             digit_dark_s;
    logic [3:0]       an_nxt_s;
    logic [6:0]       seg_nxt_s;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;

    // Display registers: bus writes, either or both bytes per strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msb_reg_r <= 8'h00;
            lsb_reg_r <= 8'h00;
        end else if (we && en7seg) begin
            if (en7segMSB) begin
                msb_reg_r <= data_in;
            end
            if (en7segLSB) begin
                lsb_reg_r <= data_in;
            end
        end
    end

    // Combinational read-back. MSB wins if both selects are high.
    always_comb begin
        data_out = 8'h00;
        if (en7seg && en7segMSB) begin
            data_out = msb_reg_r;
        end else if (en7seg && en7segLSB) begin
            data_out = lsb_reg_r;
        end else begin
            data_out = 8'h00;
        end
    end

    assign tick_s = (presc_r == LAST_CNT);

    // Scan state register: prescaler and current digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= CNT_ZERO;
            idx_r   <= 2'd0;
        end else begin
            presc_r <= presc_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Scan next state: the prescaler wraps on tick and the index advances mod 4.
    always_comb begin
        presc_nxt_s = presc_r;
        idx_nxt_s   = idx_r;
        if (tick_s) begin
            presc_nxt_s = CNT_ZERO;
            idx_nxt_s   = idx_r + 2'd1;
        end else begin
            presc_nxt_s = presc_r + CNT_ONE;
            idx_nxt_s   = idx_r;
        end
    end

    // Slot darkening: optional leading-zero suppression for the current digit.
    always_comb begin
        digit_dark_s = 1'b0;
`ifdef SSEG_LZB_EN
        digit_dark_s = is_leading_zero(idx_r, msb_reg_r, lsb_reg_r);
`else
        digit_dark_s = 1'b0;
`endif
    end

    // Pin values for the next cycle: blank on tick or on a dark slot, else the digit.
    always_comb begin
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_BLANK;
        if (tick_s || digit_dark_s) begin
            an_nxt_s  = AN_OFF;
            seg_nxt_s = SEG_BLANK;
        end else begin
            an_nxt_s  = idx_to_an(idx_r);
            seg_nxt_s = hex_to_seg(idx_to_nib(idx_r, msb_reg_r, lsb_reg_r));
        end
    end

    // Registered anode and segment pins; all dark while in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for sseg_mux_ctrl. Stimulus is applied on the falling edge. A
// reference model works from elapsed cycles since reset and from the
// 16-bit display value, and pushes the expected pins into a queue. A
// monitor pops one entry after every rising edge and compares it.
// ---------------------------------------------------------------------------
module tb_sseg_mux_ctrl;

    localparam int SD = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [7:0] data_in;
    logic       en7seg;
    logic       en7segMSB;
    logic       en7segLSB;
    logic [7:0] data_out;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    sseg_mux_ctrl #(.SCAN_DIV(SD), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .data_in   (data_in),
        .en7seg    (en7seg),
        .en7segMSB (en7segMSB),
        .en7segLSB (en7segLSB),
        .data_out  (data_out),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [7:0] dout;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    // Reference model state
    logic [7:0] m_msb;
    logic [7:0] m_lsb;
    int         m_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called on a falling edge: drive inputs, predict what the next rising edge gives.
    task automatic step(input logic w, input logic e, input logic m,
                        input logic l, input logic [7:0] d);
        exp_t       x;
        int         pre;
        int         idx;
        int         value;
        int         nib;
        logic       dark;
        logic [3:0] one;
        one       = 4'b0001;
        we        = w;
        en7seg    = e;
        en7segMSB = m;
        en7segLSB = l;
        data_in   = d;
        pre   = m_cyc % SD;
        idx   = (m_cyc / SD) % 4;
        value = {16'h0000, m_msb, m_lsb};
        nib   = (value >> (4 * idx)) & 15;
        dark  = (pre == SD - 1);
`ifdef SSEG_LZB_EN
        if (idx > 0 && (value >> (4 * idx)) == 0) dark = 1'b1;
`endif
        x.an  = dark ? 4'b1111 : ~(one << idx);
        x.seg = dark ? 7'b1111111 : SEG_TAB[nib];
        if (w && e) begin
            if (m) m_msb = d;
            if (l) m_lsb = d;
        end
        x.dout = (e && m) ? m_msb : ((e && l) ? m_lsb : 8'h00);
        m_cyc++;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, i[0], ~i[0], 8'h00);
        end
    endtask

    // Reset asserted between edges: the pins must go dark at once and the registers clear.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp", {31'h0, dp}, 32'h1);
        we = 1'b0; en7seg = 1'b1; en7segMSB = 1'b1; en7segLSB = 1'b0;
        #1;
        chk("rst_rd_msb", {24'h0, data_out}, 32'h0);
        en7segMSB = 1'b0; en7segLSB = 1'b1;
        #1;
        chk("rst_rd_lsb", {24'h0, data_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        en7seg = 1'b0; en7segLSB = 1'b0;
        m_msb = 8'h00;
        m_lsb = 8'h00;
        m_cyc = 0;
    endtask

    // Monitor: one expected entry per rising edge while the bench is stepping.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("an", {28'h0, an}, {28'h0, e.an});
            chk("seg", {25'h0, seg}, {25'h0, e.seg});
            chk("dp", {31'h0, dp}, 32'h1);
            chk("data_out", {24'h0, data_out}, {24'h0, e.dout});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        reset = 1'b1;
        we = 1'b0; data_in = 8'h00; en7seg = 1'b0; en7segMSB = 1'b0; en7segLSB = 1'b0;
        m_msb = 8'h00; m_lsb = 8'h00; m_cyc = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(3);
        mid_reset();

        // Write and read back, then watch full scans of 0x1234
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h12);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h34);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        idle(20);

        // Writes that must be ignored
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        idle(4);

        // Both selects in one write
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hA7);
        idle(8);

        // Reset while digit 2 is showing
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h9C);
        while (!((m_cyc / SD) % 4 == 2 && m_cyc % SD == 1)) idle(1);
        mid_reset();
        idle(6);

        // Leading-zero patterns
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h05);
        idle(18);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
        idle(16);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        idle(16);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h01);
        idle(16);

        // Random traffic, including writes landing on tick edges
        for (int i = 0; i < 400; i++) begin
            d = ($urandom % 3 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom % 4 == 0) d = d & 8'h0F;
            step(1'($urandom % 2), 1'($urandom % 4 != 0),
                 1'($urandom % 2), 1'($urandom % 2), d);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
